// File: rtl/tb_fetch_ctrl_if.sv
// Bus between the fetch controller, the line SRAM and the transpose buffer.
// The master side is the environment that commands fetches and hosts the SRAM.
interface tb_fetch_ctrl_if #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned PIXEL_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 10
);
    logic                               start;
    logic [ADDR_WIDTH-1:0]              base_addr;
    logic [CNT_WIDTH-1:0]               num_pixels;
    logic                               stall;
    logic                               mem_ren;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic [FETCH_WIDTH*PIXEL_WIDTH-1:0] mem_rdata;
    logic [FETCH_WIDTH*PIXEL_WIDTH-1:0] mem_data;
    logic [FETCH_WIDTH-1:0]             valid_input;
    logic                               busy;
    logic                               done;

    modport master (
        output start, base_addr, num_pixels, stall, mem_rdata,
        input  mem_ren, mem_addr, mem_data, valid_input, busy, done
    );

    modport slave (
        input  start, base_addr, num_pixels, stall, mem_rdata,
        output mem_ren, mem_addr, mem_data, valid_input, busy, done
    );
endinterface

// File: rtl/tb_fetch_ctrl.sv
// Fetch controller: streams a contiguous pixel run from the line SRAM, one word per cycle,
// and presents each returned word with a per-lane valid mask to the transpose buffer.
module tb_fetch_ctrl #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned PIXEL_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 10
) (
    input logic            clk,
    input logic            rst_n,
    tb_fetch_ctrl_if.slave bus
);
    localparam int unsigned DataW = FETCH_WIDTH * PIXEL_WIDTH;
    localparam int unsigned CntW1 = CNT_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_WIDTH:0]     words_q, words_d;
    logic [FETCH_WIDTH-1:0] tail_mask_q, tail_mask_d;

    // Side pipe entry 0: aligned with mem_rdata; entry 1 is the output register.
    logic                   p1_vld_q, p1_last_q;
    logic [FETCH_WIDTH-1:0] p1_mask_q, p1_mask_d;
    logic [DataW-1:0]       data_q, data_d;
    logic [FETCH_WIDTH-1:0] valid_q, valid_d;
    logic                   done_q, done_d;

    logic                   ren;
    logic                   issue_last;
    logic                   zero_done;
    logic [CNT_WIDTH:0]     words_calc;
    logic [CNT_WIDTH-1:0]   rem_calc;
    logic [FETCH_WIDTH-1:0] tail_calc;

    always_comb begin
        words_calc = ({1'b0, bus.num_pixels} + CntW1'(FETCH_WIDTH - 1)) / CntW1'(FETCH_WIDTH);
        rem_calc   = bus.num_pixels % CNT_WIDTH'(FETCH_WIDTH);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            tail_calc[i] = (rem_calc == '0) || (CNT_WIDTH'(i) < rem_calc);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        words_d     = words_q;
        tail_mask_d = tail_mask_q;
        ren         = 1'b0;
        issue_last  = 1'b0;
        zero_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with done belongs to the previous command's tail.
                if (bus.start && !done_q) begin
                    addr_d      = bus.base_addr;
                    words_d     = words_calc;
                    tail_mask_d = tail_calc;
                    if (bus.num_pixels == '0) begin
                        zero_done = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!bus.stall) begin
                    ren     = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    words_d = words_q - 1'b1;
                    if (words_q == CntW1'(1)) begin
                        issue_last = 1'b1;
                        state_d    = StDrain;
                    end
                end
            end
            StDrain: begin
                if (done_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        p1_mask_d = issue_last ? tail_mask_q : '1;
        valid_d   = p1_vld_q ? p1_mask_q : '0;
        done_d    = (p1_vld_q && p1_last_q) || zero_done;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            data_d[i*PIXEL_WIDTH +: PIXEL_WIDTH] = (p1_vld_q && p1_mask_q[i]) ?
                bus.mem_rdata[i*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            words_q     <= '0;
            tail_mask_q <= '0;
            p1_vld_q    <= 1'b0;
            p1_last_q   <= 1'b0;
            p1_mask_q   <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            tail_mask_q <= tail_mask_d;
            p1_vld_q    <= ren;
            p1_last_q   <= issue_last;
            p1_mask_q   <= p1_mask_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.mem_ren     = ren;
    assign bus.mem_addr    = ren ? addr_q : '0;
    assign bus.mem_data    = data_q;
    assign bus.valid_input = valid_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_tb_fetch_ctrl.sv
// Bench for tb_fetch_ctrl: directed scenarios with literal expectations plus randomized
// commands, stalls and stray starts, all checked every cycle against a queue-based model.
module tb_tb_fetch_ctrl;
    localparam int FW = 4;
    localparam int PW = 1;
    localparam int AW = 8;
    localparam int CW = 10;
    localparam int DW = FW * PW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tb_fetch_ctrl_if #(.FETCH_WIDTH(FW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    tb_fetch_ctrl #(.FETCH_WIDTH(FW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [2**AW];

    // Line SRAM: one-cycle read latency; garbage on idle cycles so masking is observable.
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
        else             bus.mem_rdata <= DW'($urandom);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the whole command is expanded into a word list at start time.
    typedef struct { int addr; logic [FW-1:0] mask; bit last; } word_t;
    typedef struct { int c; logic [DW-1:0] data; logic [FW-1:0] mask; bit last; } out_t;

    word_t pending[$];
    out_t  outq[$];
    bit    m_busy    = 0;
    int    zdone_cyc = -1;

    int    ren_addr_log[$];
    int    ren_cyc_log[$];
    out_t  out_log[$];
    int    done_log[$];
    bit    busy_seen;

    function automatic logic [DW-1:0] apply_mask(logic [DW-1:0] d, logic [FW-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < FW; i++) if (m[i]) r[i*PW +: PW] = d[i*PW +: PW];
        return r;
    endfunction

    task automatic model_start(input int base, input int n);
        int    words;
        int    rem;
        word_t w;
        words = (n + FW - 1) / FW;
        rem   = n % FW;
        for (int k = 0; k < words; k++) begin
            w.addr = (base + k) % (2**AW);
            w.last = (k == words - 1);
            w.mask = (w.last && rem != 0) ? FW'((1 << rem) - 1) : '1;
            pending.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        bit            exp_ren, have_out, exp_done, was_busy;
        logic [AW-1:0] exp_addr;
        out_t          o;
        word_t         w;
        if (!rst_n) begin
            pending.delete();
            outq.delete();
            m_busy    = 0;
            zdone_cyc = -1;
            chk("rst_ren",   bus.mem_ren,     0);
            chk("rst_valid", bus.valid_input, 0);
            chk("rst_data",  bus.mem_data,    0);
            chk("rst_busy",  bus.busy,        0);
            chk("rst_done",  bus.done,        0);
        end else begin
            was_busy = m_busy;
            exp_ren  = m_busy && pending.size() != 0 && !bus.stall;
            exp_addr = exp_ren ? AW'(pending[0].addr) : '0;
            have_out = outq.size() != 0 && outq[0].c == cyc;
            o.c = cyc; o.data = '0; o.mask = '0; o.last = 0;
            if (have_out) o = outq[0];
            exp_done = (have_out && o.last) || (zdone_cyc == cyc);

            chk("ren",   bus.mem_ren,     exp_ren);
            chk("addr",  bus.mem_addr,    exp_addr);
            chk("valid", bus.valid_input, o.mask);
            chk("data",  bus.mem_data,    o.data);
            chk("done",  bus.done,        exp_done);
            chk("busy",  bus.busy,        m_busy);

            if (bus.mem_ren) begin
                ren_addr_log.push_back(int'(bus.mem_addr));
                ren_cyc_log.push_back(cyc);
            end
            if (bus.valid_input != '0) begin
                out_t l;
                l.c = cyc; l.data = bus.mem_data; l.mask = bus.valid_input; l.last = bus.done;
                out_log.push_back(l);
            end
            if (bus.done) done_log.push_back(cyc);
            if (bus.busy) busy_seen = 1;

            if (have_out) begin
                void'(outq.pop_front());
                if (o.last) m_busy = 0;
            end
            if (exp_ren) begin
                out_t n;
                w      = pending.pop_front();
                n.c    = cyc + 2;
                n.data = apply_mask(mem[w.addr], w.mask);
                n.mask = w.mask;
                n.last = w.last;
                outq.push_back(n);
            end
            if (bus.start && !was_busy && !exp_done) begin
                if (bus.num_pixels == 0) zdone_cyc = cyc + 1;
                else begin
                    m_busy = 1;
                    model_start(int'(bus.base_addr), int'(bus.num_pixels));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ren_addr_log.delete();
        ren_cyc_log.delete();
        out_log.delete();
        done_log.delete();
        busy_seen = 0;
    endtask

    task automatic issue(input int base, input int n, output int s);
        bus.start      = 1'b1;
        bus.base_addr  = AW'(base);
        bus.num_pixels = CW'(n);
        s              = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_until_idle(input bit rnd);
        int n;
        n = 0;
        do begin
            if (rnd) begin
                bus.stall = ($urandom_range(0, 3) == 0);
                bus.start = bus.busy && ($urandom_range(0, 7) == 0);
                bus.base_addr  = AW'($urandom);
                bus.num_pixels = CW'($urandom_range(0, 20));
            end
            step();
            n++;
        end while ((bus.busy || m_busy || outq.size() != 0 || zdone_cyc >= cyc) && n < 2000);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        chk("idle_timeout", n < 2000, 1);
    endtask

    initial begin
        int s;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_pixels = '0; bus.stall = 1'b0;
        for (int a = 0; a < 2**AW; a++) mem[a] = DW'(a);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Aligned run
        clear_logs();
        issue('h10, 8, s);
        run_until_idle(0);
        chk("al_nren", ren_addr_log.size(), 2);
        chk("al_a0", ren_addr_log[0], 'h10);
        chk("al_a1", ren_addr_log[1], 'h11);
        chk("al_rc0", ren_cyc_log[0], s + 1);
        chk("al_nout", out_log.size(), 2);
        chk("al_o0c", out_log[0].c, s + 3);
        chk("al_o0d", out_log[0].data, 'h0);
        chk("al_o0v", out_log[0].mask, 'hF);
        chk("al_o1c", out_log[1].c, s + 4);
        chk("al_o1d", out_log[1].data, 'h1);
        chk("al_o1v", out_log[1].mask, 'hF);
        chk("al_ndone", done_log.size(), 1);
        chk("al_done", done_log[0], s + 4);

        // Partial tail
        for (int a = 0; a < 2**AW; a++) mem[a] = '1;
        clear_logs();
        issue('h20, 6, s);
        run_until_idle(0);
        chk("pt_nout", out_log.size(), 2);
        chk("pt_o0d", out_log[0].data, 'hF);
        chk("pt_o0v", out_log[0].mask, 'hF);
        chk("pt_o1d", out_log[1].data, 'h3);
        chk("pt_o1v", out_log[1].mask, 'h3);
        chk("pt_done", done_log[0], s + 4);
        for (int a = 0; a < 2**AW; a++) mem[a] = DW'(a);

        // Zero length
        clear_logs();
        issue('h33, 0, s);
        run_until_idle(0);
        chk("z_nren", ren_addr_log.size(), 0);
        chk("z_ndone", done_log.size(), 1);
        chk("z_done", done_log[0], s + 1);
        chk("z_busy", busy_seen, 0);

        // Stall for two cycles after the first read
        clear_logs();
        issue('h30, 12, s);
        step();
        bus.stall = 1'b1;
        step();
        step();
        bus.stall = 1'b0;
        run_until_idle(0);
        chk("st_nren", ren_addr_log.size(), 3);
        chk("st_a1", ren_addr_log[1], 'h31);
        chk("st_a2", ren_addr_log[2], 'h32);
        chk("st_rc1", ren_cyc_log[1], s + 4);
        chk("st_o1c", out_log[1].c, s + 6);
        chk("st_o2c", out_log[2].c, s + 7);
        chk("st_done", done_log[0], s + 7);

        // Address wrap with a stray start during RUN
        clear_logs();
        bus.start = 1'b1; bus.base_addr = 'hFF; bus.num_pixels = 8;
        s = cyc;
        step();
        bus.base_addr = 'h40; bus.num_pixels = 4;
        step();
        bus.start = 1'b0;
        run_until_idle(0);
        chk("wr_nren", ren_addr_log.size(), 2);
        chk("wr_a0", ren_addr_log[0], 'hFF);
        chk("wr_a1", ren_addr_log[1], 'h00);
        chk("wr_o0d", out_log[0].data, 'hF);
        chk("wr_o1d", out_log[1].data, 'h0);
        chk("wr_ndone", done_log.size(), 1);
        chk("wr_done", done_log[0], s + 4);

        // Reset mid-run
        clear_logs();
        issue('h50, 40, s);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mr_ren", bus.mem_ren, 0);
        chk("mr_addr", bus.mem_addr, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_valid", bus.valid_input, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mr_nodone", done_log.size(), 0);
        clear_logs();
        issue('h60, 4, s);
        run_until_idle(0);
        chk("mr_nren", ren_addr_log.size(), 1);
        chk("mr_a0", ren_addr_log[0], 'h60);
        chk("mr_rc0", ren_cyc_log[0], s + 1);
        chk("mr_done", done_log[0], s + 3);

        // Randomized commands
        for (int a = 0; a < 2**AW; a++) mem[a] = DW'($urandom);
        for (int k = 0; k < 80; k++) begin
            int n;
            repeat ($urandom_range(0, 2)) step();
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 24);
            issue($urandom_range(0, 255), n, s);
            run_until_idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
